// File: rtl/button_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types and default constants for the push-button debouncer slice.
// Contents:
//   deb_state_t          per-channel debounce state (STABLE / SETTLING)
//   SYNC_STAGES          depth of the input synchroniser chain
//   DEF_*                default parameter values (100 MHz board timing)
// -----------------------------------------------------------------------------
package button_pkg;

   typedef enum logic {
      STABLE   = 1'b0,
      SETTLING = 1'b1
   } deb_state_t;

   localparam int SYNC_STAGES         = 2;
   localparam int DEF_N_BUT           = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 100000;    // 1 ms at 100 MHz
   localparam int DEF_CNT_W           = 17;
   localparam int DEF_LONG_CYCLES     = 50000000;  // 0.5 s at 100 MHz

endpackage

// File: rtl/button_debouncer_if.sv
// -----------------------------------------------------------------------------
// button_debouncer_if
// Bundles the raw button pins and the conditioned outputs of the debouncer.
// Signals (all N_BUT wide, one bit per channel):
//   BUT            raw pins, active-low, asynchronous to clk
//   level          debounced state, active-high
//   press          one-cycle pulse on an accepted press
//   release_pulse  one-cycle pulse on an accepted release
//                  (release is a reserved word in SystemVerilog)
//   long_press     one-cycle pulse after a sustained hold
// Modports:
//   master  board / consumer side: drives BUT, observes the outputs
//   slave   debouncer side: samples BUT, drives the outputs
// -----------------------------------------------------------------------------
interface button_debouncer_if #(
   parameter int N_BUT = 2
);

   logic [N_BUT-1:0] BUT;
   logic [N_BUT-1:0] level;
   logic [N_BUT-1:0] press;
   logic [N_BUT-1:0] release_pulse;
   logic [N_BUT-1:0] long_press;

   modport master (
      output BUT,
      input  level,
      input  press,
      input  release_pulse,
      input  long_press
   );

   modport slave (
      input  BUT,
      output level,
      output press,
      output release_pulse,
      output long_press
   );

endinterface

// File: rtl/button_debouncer_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One button channel: synchroniser, debounce FSM with stability counter and,
// when LONG_PRESS_EN is defined, a saturating hold counter for long_press.
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   but            raw pin, active-low, asynchronous to clk
//   level          debounced state, active-high
//   press          one-cycle pulse when a press is accepted
//   release_pulse  one-cycle pulse when a release is accepted
//   long_press     one-cycle pulse LONG_CYCLES after press (0 without macro)
// Macro: LONG_PRESS_EN enables the hold counter and LONG_CYCLES parameter.
// -----------------------------------------------------------------------------
module debounce_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
`ifdef LONG_PRESS_EN
   ,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
`endif
) (
   input  logic clk,
   input  logic reset_n,
   input  logic but,
   output logic level,
   output logic press,
   output logic release_pulse,
   output logic long_press
);

   localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   deb_state_t             state;
   logic [CNT_W-1:0]       cnt;

   // Synchroniser resets to the released pin level (1).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync <= '1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], but};
      end
   end

   assign s = ~sync[SYNC_STAGES-1];

   // The accept test comes before the increment, so cnt tops out at
   // DEBOUNCE_CYCLES-1 and never wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= STABLE;
         cnt           <= '0;
         level         <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press         <= 1'b0;
         release_pulse <= 1'b0;
         case (state)
            STABLE: begin
               if (s != level) begin
                  state <= SETTLING;
                  cnt   <= CNT_W'(1);
               end
            end
            SETTLING: begin
               if (s == level) begin
                  state <= STABLE;
                  cnt   <= '0;
               end else if (cnt == ACCEPT_AT) begin
                  level         <= ~level;
                  press         <= ~level;
                  release_pulse <= level;
                  state         <= STABLE;
                  cnt           <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= STABLE;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef LONG_PRESS_EN
   localparam int               HOLD_W   = $clog2(LONG_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

   logic [HOLD_W-1:0] hold_cnt;

   // level is still 0 on the press edge, so the counter starts from zero
   // for every new press; saturation at HOLD_MAX gives one pulse per press.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_cnt   <= '0;
         long_press <= 1'b0;
      end else begin
         long_press <= 1'b0;
         if (!level) begin
            hold_cnt <= '0;
         end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt   <= hold_cnt + 1'b1;
            long_press <= (hold_cnt == HOLD_MAX - 1'b1);
         end
      end
   end
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Conditions the board push-buttons: synchronises the raw active-low pins
// into clk and filters contact bounce, one independent channel per button.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      button_debouncer_if.slave (BUT in; level, press, release_pulse,
//            long_press out; all N_BUT wide)
// Macro: LONG_PRESS_EN adds the per-channel long-press hold counter.
// -----------------------------------------------------------------------------
module button_debouncer
   import button_pkg::*;
#(
   parameter int N_BUT           = DEF_N_BUT,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
`ifdef LONG_PRESS_EN
   ,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
`endif
) (
   input  logic              clk,
   input  logic              reset_n,
   button_debouncer_if.slave bus
);

   logic [N_BUT-1:0] level_w;
   logic [N_BUT-1:0] press_w;
   logic [N_BUT-1:0] release_w;
   logic [N_BUT-1:0] long_w;

   for (genvar i = 0; i < N_BUT; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
`ifdef LONG_PRESS_EN
         ,
         .LONG_CYCLES     (LONG_CYCLES)
`endif
      ) u_ch (
         .clk           (clk),
         .reset_n       (reset_n),
         .but           (bus.BUT[i]),
         .level         (level_w[i]),
         .press         (press_w[i]),
         .release_pulse (release_w[i]),
         .long_press    (long_w[i])
      );
   end

   assign bus.level         = level_w;
   assign bus.press         = press_w;
   assign bus.release_pulse = release_w;
   assign bus.long_press    = long_w;

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
// Directed bench for button_debouncer with DEBOUNCE_CYCLES = 8, LONG_CYCLES = 20.
// Clean input edge -> accepted event LAT = 2 + 8 = 10 edges later; long_press
// (LONG_PRESS_EN only) LONG_AT = 10 + 20 = 30 edges after the input edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_button_debouncer;

   localparam int NB      = 2;
   localparam int DC      = 8;
   localparam int CW      = 4;
   localparam int LC      = 20;
   localparam int LAT     = 2 + DC;
   localparam int LONG_AT = LAT + LC;
`ifdef LONG_PRESS_EN
   localparam bit LP = 1'b1;
`else
   localparam bit LP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   button_debouncer_if #(.N_BUT(NB)) bus ();

   button_debouncer #(
      .N_BUT           (NB),
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (CW)
`ifdef LONG_PRESS_EN
      ,
      .LONG_CYCLES     (LC)
`endif
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [NB-1:0] l, input logic [NB-1:0] p,
                          input logic [NB-1:0] r, input logic [NB-1:0] lp);
      chk({tag, ".level"},   bus.level,         l);
      chk({tag, ".press"},   bus.press,         p);
      chk({tag, ".release"}, bus.release_pulse, r);
      chk({tag, ".long"},    bus.long_press,    lp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs n edges after an input change made just now; level switches from
   // lvl0 to lvl1 at edge LAT where the press/release masks pulse, and the
   // long mask pulses at edge LONG_AT when the feature is built in.
   task automatic expect_event(input string tag, input int n,
                               input logic [NB-1:0] lvl0, input logic [NB-1:0] lvl1,
                               input logic [NB-1:0] pm, input logic [NB-1:0] rm,
                               input logic [NB-1:0] lm);
      for (int e = 1; e <= n; e++) begin
         tick();
         chk_all($sformatf("%s@%0d", tag, e),
                 (e >= LAT) ? lvl1 : lvl0,
                 (e == LAT) ? pm : 2'b00,
                 (e == LAT) ? rm : 2'b00,
                 (LP && e == LONG_AT) ? lm : 2'b00);
      end
   endtask

   initial begin
      reset_n = 1'b1;
      bus.BUT = 2'b00;
      #2 reset_n = 1'b0;
      #1;
      chk_all("reset_async0", 2'b00, 2'b00, 2'b00, 2'b00);
      repeat (3) tick();
      chk_all("reset_hold", 2'b00, 2'b00, 2'b00, 2'b00);

      // Both buttons held through reset.
      reset_n = 1'b1;
      expect_event("held_through_reset", 40, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11);

      // Partial release interrupted by an asynchronous reset between edges.
      bus.BUT = 2'b11;
      expect_event("partial_release", 6, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
      #2 reset_n = 1'b0;
      #1;
      chk_all("async_reset", 2'b00, 2'b00, 2'b00, 2'b00);
      tick();
      tick();
      chk_all("in_reset", 2'b00, 2'b00, 2'b00, 2'b00);
      reset_n = 1'b1;
      expect_event("quiet_after_reset", 12, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

      // Partial press count must be discarded by reset.
      bus.BUT = 2'b10;
      expect_event("partial_press", 6, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      #2 reset_n = 1'b0;
      #1;
      chk_all("async_reset2", 2'b00, 2'b00, 2'b00, 2'b00);
      tick();
      reset_n = 1'b1;
      expect_event("press_after_reset", 12, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
      bus.BUT = 2'b11;
      expect_event("release_ch0", 12, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);

      // Clean press and release on channel 0; channel 1 stays idle.
      bus.BUT = 2'b10;
      expect_event("clean_press", 14, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
      bus.BUT = 2'b11;
      expect_event("clean_release", 12, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);

      // Bounce: 3-cycle segments for 30 cycles, then settle pressed.
      for (int k = 0; k < 10; k++) begin
         bus.BUT[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
         expect_event($sformatf("bounce%0d", k), 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      end
      bus.BUT[0] = 1'b0;
      expect_event("bounce_settle", 40, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);

      // 7-cycle glitch on channel 1 while channel 0 stays held.
      bus.BUT = 2'b00;
      expect_event("glitch_low", 7, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
      bus.BUT = 2'b10;
      expect_event("glitch_after", 15, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);

      // Press channel 1, then release both on the same cycle.
      bus.BUT = 2'b00;
      expect_event("press_ch1", 40, 2'b01, 2'b11, 2'b10, 2'b00, 2'b10);
      bus.BUT = 2'b11;
      expect_event("release_both", 15, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
